// File: rtl/pcpi_result_nibble_tx_pkg.sv
// Shared definitions for the nibble-serial host link (inbound receiver and result transmitter).
package pcpi_result_nibble_tx_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StPresent = 2'b01,
        StRelease = 2'b10
    } link_state_e;

    localparam int unsigned LINK_DATA_W      = 32;
    localparam int unsigned LINK_NIB_W       = 4;
    localparam int unsigned NIBBLES_PER_WORD = LINK_DATA_W / LINK_NIB_W;

    // Counter width helper: never returns less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/pcpi_result_nibble_tx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module pcpi_result_nibble_tx_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pcpi_result_nibble_tx.sv
// Sends a PCPI result word to the host as LSB-first nibbles, each with a four-phase valid/ack.
module pcpi_result_nibble_tx
    import pcpi_result_nibble_tx_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NIB_W       = 4,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [NIB_W-1:0]  tx_nibble,
    output logic              tx_valid,
    input  logic              tx_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned NIBBLES = DATA_W / NIB_W;
    localparam int unsigned CNT_W   = clog2_min1(NIBBLES);
    localparam int unsigned TMR_W   = clog2_min1(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_NIB  = CNT_W'(NIBBLES - 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = (ACK_TIMEOUT == 0) ? '0 : TMR_W'(ACK_TIMEOUT - 1);

    link_state_e       state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ack_s;
    logic              timeout;

    pcpi_result_nibble_tx_sync_2ff u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (tx_ack),
        .q   (ack_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            count_q <= '0;
            timer_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            count_q <= count_d;
            timer_q <= timer_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = err_q;
        timeout = (ACK_TIMEOUT != 0) && (timer_q == TMR_LIMIT);

        // Handshake exit is tested before timeout so it wins on a shared edge.
        unique case (state_q)
            StIdle: begin
                if (load_valid && load_ready) begin
                    sreg_d  = load_data;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (ack_s) begin
                    state_d = StRelease;
                end else if (timeout) begin
                    state_d = StIdle;
                    sreg_d  = '0;
                    count_d = '0;
                    err_d   = 1'b1;
                end
            end
            StRelease: begin
                if (!ack_s) begin
                    if (count_q == LAST_NIB) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        sreg_d  = sreg_q >> NIB_W;
                        count_d = count_q + 1'b1;
                        state_d = StPresent;
                    end
                end else if (timeout) begin
                    state_d = StIdle;
                    sreg_d  = '0;
                    count_d = '0;
                    err_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Timer measures time spent in the current handshake phase only.
        if ((state_d != state_q) || (state_q == StIdle)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    assign load_ready = (state_q == StIdle) && !ack_s;
    assign tx_valid   = (state_q == StPresent);
    assign busy       = (state_q != StIdle);
    assign tx_nibble  = busy ? sreg_q[NIB_W-1:0] : '0;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pcpi_result_nibble_tx.sv
// Bench for pcpi_result_nibble_tx: vector table, hand-written corner sequences, random words.
module tb_pcpi_result_nibble_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic [3:0]  tx_nibble;
    logic        tx_valid;
    logic        tx_ack;
    logic        busy;
    logic        done;
    logic        err;

    logic        to_load_valid;
    logic [31:0] to_load_data;
    logic        to_load_ready;
    logic [3:0]  to_tx_nibble;
    logic        to_tx_valid;
    logic        to_tx_ack;
    logic        to_busy;
    logic        to_done;
    logic        to_err;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int to_done_cnt = 0;
    int nib_unstable = 0;

    always #5 clk = ~clk;

    pcpi_result_nibble_tx u_dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .tx_nibble  (tx_nibble),
        .tx_valid   (tx_valid),
        .tx_ack     (tx_ack),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    pcpi_result_nibble_tx #(
        .ACK_TIMEOUT (8)
    ) u_dut_to (
        .clk        (clk),
        .rst        (rst),
        .load_valid (to_load_valid),
        .load_data  (to_load_data),
        .load_ready (to_load_ready),
        .tx_nibble  (to_tx_nibble),
        .tx_valid   (to_tx_valid),
        .tx_ack     (to_tx_ack),
        .busy       (to_busy),
        .done       (to_done),
        .err        (to_err)
    );

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (to_done === 1'b1) to_done_cnt <= to_done_cnt + 1;
    end

    typedef struct {
        logic [31:0] word;
        logic [31:0] seq;   // emitted nibbles, first one in bits [31:28]
        int          dly;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: emission order is the word's nibbles from least significant upward.
    function automatic logic [31:0] model_seq(input logic [31:0] w);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = (s << 4) | ((w >> (4 * i)) & 32'hF);
        return s;
    endfunction

    task automatic accept(input logic [31:0] word);
        int t;
        t = 0;
        while (load_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("load_ready_before_accept", {31'd0, load_ready}, 32'd1);
        load_valid = 1'b1;
        load_data  = word;
        @(negedge clk);
        load_valid = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("err_after_accept", {31'd0, err}, 32'd0);
    endtask

    // Host side of one nibble: see valid, ack after dly cycles, see valid drop, release.
    task automatic host_nibble(input int dly, output logic [3:0] nib);
        int t;
        t = 0;
        while (tx_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        nib = tx_nibble;
        repeat (dly) begin
            @(negedge clk);
            if (tx_nibble !== nib) nib_unstable++;
        end
        tx_ack = 1'b1;
        t = 0;
        while (tx_valid !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
            if (tx_nibble !== nib) nib_unstable++;
        end
        check("valid_fall_after_ack", {31'd0, tx_valid}, 32'd0);
        tx_ack = 1'b0;
    endtask

    task automatic finish_word(input int d0);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("idle_after_word", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("done_pulse_cycles", done_cnt - d0, 32'd1);
        check("err_after_word", {31'd0, err}, 32'd0);
        check("load_ready_after_word", {31'd0, load_ready}, 32'd1);
        check("nibble_stable", nib_unstable, 32'd0);
    endtask

    task automatic xfer(input logic [31:0] word, input int dly, output logic [31:0] seq);
        logic [3:0] nib;
        int d0;
        d0 = done_cnt;
        accept(word);
        seq = '0;
        for (int i = 0; i < 8; i++) begin
            host_nibble(dly, nib);
            seq = {seq[27:0], nib};
        end
        finish_word(d0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] seq;
        logic [31:0] w;
        logic [3:0]  nib;
        int          d0;
        int          bad;
        int          edges;
        int          hi;

        vecs[0] = '{word: 32'hDEADBEEF, seq: 32'hFEEBDAED, dly: 0};
        vecs[1] = '{word: 32'h12345678, seq: 32'h87654321, dly: 2};
        vecs[2] = '{word: 32'hFFFFFFFF, seq: 32'hFFFFFFFF, dly: 1};
        vecs[3] = '{word: 32'h00000000, seq: 32'h00000000, dly: 3};
        vecs[4] = '{word: 32'h80000001, seq: 32'h10000008, dly: 0};
        vecs[5] = '{word: 32'hCAFEF00D, seq: 32'hD00FEFAC, dly: 1};

        rst           = 1'b1;
        load_valid    = 1'b0;
        load_data     = '0;
        tx_ack        = 1'b0;
        to_load_valid = 1'b0;
        to_load_data  = '0;
        to_tx_ack     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_nibble", {28'd0, tx_nibble}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_load_ready", {31'd0, load_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            xfer(vecs[i].word, vecs[i].dly, seq);
            check($sformatf("vec%0d_seq", i), seq, vecs[i].seq);
        end

        // Latency: raw ack rises 5 cycles into PRESENT; valid must fall 3 edges later.
        d0 = done_cnt;
        bad = 0;
        accept(32'hA5C30F96);
        nib = tx_nibble;
        check("lat_valid_up", {31'd0, tx_valid}, 32'd1);
        repeat (4) begin
            @(negedge clk);
            if (tx_nibble !== nib || tx_valid !== 1'b1) bad++;
        end
        tx_ack = 1'b1;
        edges = 0;
        while (tx_valid === 1'b1 && edges < 20) begin
            @(negedge clk);
            edges++;
            if (tx_nibble !== nib) bad++;
        end
        check("lat_ack_rise_edges", edges, 32'd3);
        tx_ack = 1'b0;
        edges = 0;
        while (tx_valid !== 1'b1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("lat_ack_fall_edges", edges, 32'd3);
        check("lat_nibble_stable", bad, 32'd0);
        seq = {28'd0, nib};
        for (int i = 1; i < 8; i++) begin
            host_nibble(1, nib);
            seq = {seq[27:0], nib};
        end
        finish_word(d0);
        check("lat_seq", seq, model_seq(32'hA5C30F96));

        // Backpressure: a load pulse mid-transfer must be dropped.
        d0 = done_cnt;
        accept(32'hCAFEF00D);
        seq = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                load_valid = 1'b1;
                load_data  = 32'h12345678;
                @(negedge clk);
                check("bp_load_ready_low", {31'd0, load_ready}, 32'd0);
                @(negedge clk);
                load_valid = 1'b0;
            end
            host_nibble(0, nib);
            seq = {seq[27:0], nib};
        end
        finish_word(d0);
        check("bp_seq", seq, 32'hD00FEFAC);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        check("bp_no_second_word", bad, 32'd0);

        // Ack stuck high in RELEASE: no advance, no duplicate.
        d0 = done_cnt;
        accept(32'h0F1E2D3C);
        nib = tx_nibble;
        check("stuck_rel_nib0", {28'd0, nib}, 32'hC);
        tx_ack = 1'b1;
        repeat (5) @(negedge clk);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || busy !== 1'b1 || tx_nibble !== nib) bad++;
        end
        check("stuck_rel_hold", bad, 32'd0);
        tx_ack = 1'b0;
        seq = {28'd0, nib};
        for (int i = 1; i < 8; i++) begin
            host_nibble(2, nib);
            seq = {seq[27:0], nib};
        end
        finish_word(d0);
        check("stuck_rel_seq", seq, model_seq(32'h0F1E2D3C));

        // Timeout instance: host never acks.
        d0 = to_done_cnt;
        to_load_valid = 1'b1;
        to_load_data  = 32'h13579BDF;
        @(negedge clk);
        to_load_valid = 1'b0;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            if (to_tx_valid === 1'b1) hi++;
            @(negedge clk);
        end
        check("to_valid_cycles", hi, 32'd8);
        check("to_err_set", {31'd0, to_err}, 32'd1);
        check("to_busy_low", {31'd0, to_busy}, 32'd0);
        check("to_no_done", to_done_cnt - d0, 32'd0);
        check("to_load_ready", {31'd0, to_load_ready}, 32'd1);
        to_load_valid = 1'b1;
        to_load_data  = 32'h2468ACE0;
        @(negedge clk);
        to_load_valid = 1'b0;
        check("to_err_cleared", {31'd0, to_err}, 32'd0);
        check("to_reaccept_busy", {31'd0, to_busy}, 32'd1);

        // Asynchronous reset during the 4th nibble.
        accept(32'h87654321);
        for (int i = 0; i < 3; i++) host_nibble(0, nib);
        repeat (4) @(negedge clk);
        check("pre_reset_valid", {31'd0, tx_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, tx_valid}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_nibble", {28'd0, tx_nibble}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(32'h0000000A, 1, seq);
        check("reload_first_nibble", {28'd0, seq[31:28]}, 32'hA);
        check("reload_seq", seq, 32'hA0000000);

        // Ack stuck high in IDLE blocks loads; release lets the pending word in.
        tx_ack = 1'b1;
        repeat (4) @(negedge clk);
        load_valid = 1'b1;
        load_data  = 32'h5A5A5A5A;
        d0 = done_cnt;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (load_ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("stuck_idle_blocked", bad, 32'd0);
        tx_ack = 1'b0;
        edges = 0;
        while (busy !== 1'b1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        load_valid = 1'b0;
        check("stuck_idle_accept_edges", {31'd0, (edges >= 2 && edges <= 3)}, 32'd1);
        seq = '0;
        for (int i = 0; i < 8; i++) begin
            host_nibble(1, nib);
            seq = {seq[27:0], nib};
        end
        finish_word(d0);
        check("stuck_idle_seq", seq, model_seq(32'h5A5A5A5A));

        for (int n = 0; n < 20; n++) begin
            w = $urandom;
            xfer(w, int'($urandom_range(0, 3)), seq);
            check($sformatf("rand%0d_seq", n), seq, model_seq(w));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcpi_result_nibble_tx.md
Name: pcpi_result_nibble_tx

Overview:
- Return-path transmitter for the nibble-serial host link. The inbound path shifts a 32-bit instruction in as eight 4-bit segments and hands it to the PCPI unit.
- This block takes the 32-bit PCPI result (pcpi_rd when pcpi_ready && pcpi_wr). It sends the result back to the host as eight 4-bit nibbles, least-significant first.
- Each nibble uses a four-phase valid/ack handshake on the pads.
- Sits between the PCPI coprocessor and uo_out/ui_in in the top level.

Parameters:
- DATA_W, 32, result word width; must be a multiple of NIB_W.
- NIB_W, 4, nibble width on the pad bus.
- ACK_TIMEOUT, 1023, maximum cycles to wait in any handshake phase; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- load_valid  in  1  result word available.
- load_data  in  DATA_W  result word (pcpi_rd).
- load_ready  out  1  block can accept a word.
- tx_nibble  out  NIB_W  current nibble to the pads.
- tx_valid  out  1  nibble is valid (sending strobe to the host).
- tx_ack  in  1  host acknowledge, raw from the pad, asynchronous.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the last nibble's handshake completes.
- err  out  1  sticky timeout flag; cleared when the next word is accepted.

Behaviour:
- Reset: one clock; rst is asynchronous, active-high. While rst is high all state clears immediately:
  - state=IDLE, count=0, shift register=0, sync flops=0, timer=0.
  - tx_valid=0, tx_nibble=0, busy=0, done=0, err=0.
- Acknowledge sync: tx_ack passes through a 2-flop synchronizer to produce ack_s. All decisions use ack_s only.
- load_ready = (state==IDLE) && !ack_s. A stuck-high host ack blocks new loads.
- Accept: a word is accepted on an edge where load_valid && load_ready. On that edge:
  - load_data goes into the shift register; count=0; err clears.
  - state goes to PRESENT.
  - In the next cycle, tx_valid=1 and tx_nibble=load_data[3:0].
- States:
  - IDLE: tx_valid=0, busy=0. Leaves only on accept.
  - PRESENT: tx_valid=1, tx_nibble=sreg[NIB_W-1:0], busy=1.
    - On an edge with ack_s=1: go to RELEASE and drop tx_valid (registered).
    - tx_nibble holds its value through RELEASE.
  - RELEASE: tx_valid=0, busy=1. On an edge with ack_s=0:
    - If count==DATA_W/NIB_W-1: go to IDLE and pulse done=1 for exactly one cycle. tx_nibble returns to 0.
    - Otherwise: shift sreg right by NIB_W, count+1, go to PRESENT.
- Latency: tx_valid falls on the edge after ack_s is first sampled high, i.e. 3 edges after a clean raw ack rise. The same 3-edge latency applies from the raw ack fall to the next tx_valid rise.
- Throughput: each nibble takes at least 6 cycles.
- Ack held high indefinitely in RELEASE: the block stays in RELEASE. No nibble advance and no duplicate nibble.
- Timeout:
  - timer clears on every state entry and increments each cycle spent in PRESENT or RELEASE.
  - If ACK_TIMEOUT!=0 and timer==ACK_TIMEOUT-1 without the exit condition: go to IDLE, tx_valid=0, err=1 (sticky), done=0.
  - count and sreg are discarded.
- load_valid during busy is ignored; no queueing. The upstream holds its word until load_ready.
- Simultaneous events:
  - Exit condition and timeout on the same edge: the exit condition wins.
  - Accept and an err-clear: err=0 on that edge.
- Reset mid-transfer: outputs drop asynchronously and the partial word is lost. The next accept restarts at nibble 0.
- Width rules: count width is clog2(DATA_W/NIB_W); timer width is clog2(ACK_TIMEOUT+1), minimum 1.

Decomposition:
- Shared package: state encoding localparams (IDLE=2'b00, PRESENT=2'b01, RELEASE=2'b10) and NIBBLES_PER_WORD = DATA_W/NIB_W. These are shared with the inbound nibble receiver so both ends use the same encoding.
- One sub-module: sync_2ff (2-flop synchronizer with asynchronous active-high reset to 0). It is reused for sending_current on the inbound side.

Test Plan:
- Basic word: load 0xDEADBEEF; a host model acks each tx_valid rise and releases after ack. Expected:
  - Nibbles F,E,E,B,D,A,E,D in that order.
  - done pulses once, 1 cycle, after the 8th release.
  - load_ready returns to 1 and err stays 0.
- Latency check: raw ack rises 5 cycles after tx_valid. Expected: tx_valid falls exactly 3 edges later and tx_nibble is stable throughout PRESENT.
- Busy backpressure: pulse load_valid with 0x12345678 during the transfer of 0xCAFEF00D. Expected:
  - Only C-A-F-E-F-0-0-D is emitted (LSB first: D,0,0,F,E,F,A,C).
  - The second word is taken only after done, if still valid.
- Timeout: ACK_TIMEOUT=8 with the host never acking. Expected:
  - tx_valid is high for 8 cycles, then 0.
  - err=1, done=0, state IDLE.
  - The next accept clears err.
- Reset mid-operation: assert rst after the 3rd nibble's release. Expected:
  - tx_valid=0 and busy=0 immediately, without waiting for a clock edge.
  - Reload with 0x0000000A: the first nibble is A.
- Stuck ack: hold tx_ack=1 in IDLE with load_valid=1. Expected:
  - load_ready=0 and no accept.
  - Drop ack: accept occurs 2–3 edges later and nibble 0 is presented.
